// File: rtl/alu_pkg.sv
// Shared constants for the ALU add sequencer: opcodes, FSM encodings and flag bit positions.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/V/Z status from the registered adder operands and the adder sum.
module alu_flag_gen (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] s,
  output logic       n,
  output logic       v,
  output logic       z
);

  assign n = s[7];
  assign z = (s == 8'h00);
  // b is already inverted for subtraction, so the plain add overflow rule covers SUB/SBC too.
  assign v = (a[7] == b[7]) && (s[7] != a[7]);

endmodule

// File: rtl/alu_add_sequencer.sv
// Handshaked register/control stage around an external 8-bit ripple adder with a
// programmable settle time and a persistent chain carry for ADC/SBC.
module alu_add_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [7:0] IN_A,
  input  logic [7:0] IN_B,
  input  logic [1:0] IN_OP,
  output logic [7:0] ADD_A,
  output logic [7:0] ADD_B,
  output logic       ADD_CIN,
  input  logic [7:0] ADD_S,
  input  logic       ADD_COUT,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [7:0] RESULT,
  output logic [3:0] FLAGS
);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] add_a_q, add_a_d;
  logic [7:0] add_b_q, add_b_d;
  logic       add_cin_q, add_cin_d;
  logic [7:0] result_q, result_d;
  logic [3:0] flags_q, flags_d;

  logic flag_n, flag_v, flag_z;

  alu_flag_gen u_flag_gen (
    .a (add_a_q),
    .b (add_b_q),
    .s (ADD_S),
    .n (flag_n),
    .v (flag_v),
    .z (flag_z)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_cin_d = add_cin_q;
    result_d  = result_q;
    flags_d   = flags_q;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          add_a_d   = IN_A;
          add_b_d   = IN_OP[1] ? ~IN_B : IN_B;
          // ADC/SBC take the chain carry; plain ADD/SUB force 0/1.
          add_cin_d = IN_OP[0] ? flags_q[FLAG_C] : IN_OP[1];
          cnt_d     = 4'(SETTLE_CYCLES - 1);
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          result_d         = ADD_S;
          flags_d[FLAG_C]  = ADD_COUT;
          flags_d[FLAG_Z]  = flag_z;
          flags_d[FLAG_V]  = flag_v;
          flags_d[FLAG_N]  = flag_n;
          state_d          = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (OUT_READY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      add_a_q   <= 8'h00;
      add_b_q   <= 8'h00;
      add_cin_q <= 1'b0;
      result_q  <= 8'h00;
      flags_q   <= 4'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

  assign IN_READY  = (state_q == S_IDLE);
  assign OUT_VALID = (state_q == S_DONE);
  assign ADD_A     = add_a_q;
  assign ADD_B     = add_b_q;
  assign ADD_CIN   = add_cin_q;
  assign RESULT    = result_q;
  assign FLAGS     = flags_q;

endmodule

// File: tb/tb_alu_add_sequencer.sv
// Directed bench for alu_add_sequencer: two instances (settle 1 and 4) each with an adder model.
module tb_alu_add_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance 1: SETTLE_CYCLES = 1
  logic       rst_n1, iv1, ir1, ac1, aco1, ov1, ordy1;
  logic [7:0] ia1, ib1, aa1, ab1, as1, res1;
  logic [1:0] iop1;
  logic [3:0] fl1;

  // Instance 2: SETTLE_CYCLES = 4
  logic       rst_n2, iv2, ir2, ac2, aco2, ov2, ordy2;
  logic [7:0] ia2, ib2, aa2, ab2, as2, res2;
  logic [1:0] iop2;
  logic [3:0] fl2;

  assign {aco1, as1} = 9'(aa1) + 9'(ab1) + 9'(ac1);
  assign {aco2, as2} = 9'(aa2) + 9'(ab2) + 9'(ac2);

  alu_add_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .CLK(clk), .RST_N(rst_n1), .IN_VALID(iv1), .IN_READY(ir1), .IN_A(ia1), .IN_B(ib1),
    .IN_OP(iop1), .ADD_A(aa1), .ADD_B(ab1), .ADD_CIN(ac1), .ADD_S(as1), .ADD_COUT(aco1),
    .OUT_VALID(ov1), .OUT_READY(ordy1), .RESULT(res1), .FLAGS(fl1)
  );

  alu_add_sequencer #(.SETTLE_CYCLES(4)) dut2 (
    .CLK(clk), .RST_N(rst_n2), .IN_VALID(iv2), .IN_READY(ir2), .IN_A(ia2), .IN_B(ib2),
    .IN_OP(iop2), .ADD_A(aa2), .ADD_B(ab2), .ADD_CIN(ac2), .ADD_S(as2), .ADD_COUT(aco2),
    .OUT_VALID(ov2), .OUT_READY(ordy2), .RESULT(res2), .FLAGS(fl2)
  );

  // Offer one transaction to dut1 (must be idle) and count edges until OUT_VALID.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         output int lat);
    iv1 = 1'b1; ia1 = a; ib1 = b; iop1 = op;
    @(posedge clk); #1;
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_txn();
    ordy1 = 1'b1;
    @(posedge clk); #1;
    ordy1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n1 = 1'b0; rst_n2 = 1'b0;
    iv1 = 1'b1; ia1 = 8'hAA; ib1 = 8'h55; iop1 = 2'b10; ordy1 = 1'b0;
    iv2 = 1'b0; ia2 = 8'h00; ib2 = 8'h00; iop2 = 2'b00; ordy2 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if ({ir1, ov1} !== 2'b10) begin failures++;
      $display("FAIL reset_handshake: got %b expected %b", {ir1, ov1}, 2'b10); end
    checks++; if ({aa1, ab1, ac1} !== 17'h0) begin failures++;
      $display("FAIL reset_adder_inputs: got %h expected %h", {aa1, ab1, ac1}, 17'h0); end
    checks++; if ({res1, fl1} !== 12'h0) begin failures++;
      $display("FAIL reset_result_flags: got %h expected %h", {res1, fl1}, 12'h0); end
    rst_n1 = 1'b1; rst_n2 = 1'b1; iv1 = 1'b0;
    @(posedge clk); #1;
    checks++; if ({ir1, ov1, ir2, ov2} !== 4'b1010) begin failures++;
      $display("FAIL reset_release_idle: got %b expected %b", {ir1, ov1, ir2, ov2}, 4'b1010); end
  endtask

  task automatic test_add();
    int lat;
    run_txn(8'h3C, 8'h14, 2'b00, lat);
    checks++; if (lat !== 1) begin failures++;
      $display("FAIL add_latency: got %0d expected %0d", lat, 1); end
    checks++; if ({res1, fl1} !== {8'h50, 4'b0000}) begin failures++;
      $display("FAIL add_basic: got %h/%b expected %h/%b", res1, fl1, 8'h50, 4'b0000); end
    checks++; if ({ir1, ab1, ac1} !== {1'b0, 8'h14, 1'b0}) begin failures++;
      $display("FAIL add_operands: got %h expected %h", {ir1, ab1, ac1}, {1'b0, 8'h14, 1'b0}); end
    finish_txn();
    checks++; if ({ir1, ov1} !== 2'b10) begin failures++;
      $display("FAIL add_return_idle: got %b expected %b", {ir1, ov1}, 2'b10); end
  endtask

  task automatic test_adc_chain();
    int lat;
    run_txn(8'hFF, 8'h01, 2'b00, lat);
    checks++; if ({res1, fl1} !== {8'h00, 4'b0011}) begin failures++;
      $display("FAIL adc_first_add: got %h/%b expected %h/%b", res1, fl1, 8'h00, 4'b0011); end
    finish_txn();
    run_txn(8'h00, 8'h00, 2'b01, lat);
    checks++; if (ac1 !== 1'b1) begin failures++;
      $display("FAIL adc_cin: got %b expected %b", ac1, 1'b1); end
    checks++; if ({res1, fl1} !== {8'h01, 4'b0000}) begin failures++;
      $display("FAIL adc_result: got %h/%b expected %h/%b", res1, fl1, 8'h01, 4'b0000); end
    finish_txn();
  endtask

  task automatic test_sub();
    int lat;
    run_txn(8'h10, 8'h20, 2'b10, lat);
    checks++; if ({ab1, ac1} !== {8'hDF, 1'b1}) begin failures++;
      $display("FAIL sub_operands: got %h expected %h", {ab1, ac1}, {8'hDF, 1'b1}); end
    checks++; if ({res1, fl1} !== {8'hF0, 4'b1000}) begin failures++;
      $display("FAIL sub_borrow: got %h/%b expected %h/%b", res1, fl1, 8'hF0, 4'b1000); end
    finish_txn();
    run_txn(8'h20, 8'h10, 2'b10, lat);
    checks++; if ({res1, fl1} !== {8'h10, 4'b0001}) begin failures++;
      $display("FAIL sub_no_borrow: got %h/%b expected %h/%b", res1, fl1, 8'h10, 4'b0001); end
    finish_txn();
    run_txn(8'h05, 8'h03, 2'b11, lat);
    checks++; if ({ab1, ac1, res1, fl1} !== {8'hFC, 1'b1, 8'h02, 4'b0001}) begin failures++;
      $display("FAIL sbc_no_borrow: got %h expected %h", {ab1, ac1, res1, fl1},
               {8'hFC, 1'b1, 8'h02, 4'b0001}); end
    finish_txn();
    run_txn(8'h03, 8'h05, 2'b11, lat);
    checks++; if ({ab1, ac1, res1, fl1} !== {8'hFA, 1'b1, 8'hFE, 4'b1000}) begin failures++;
      $display("FAIL sbc_borrow: got %h expected %h", {ab1, ac1, res1, fl1},
               {8'hFA, 1'b1, 8'hFE, 4'b1000}); end
    finish_txn();
  endtask

  task automatic test_overflow();
    int lat;
    run_txn(8'h7F, 8'h01, 2'b00, lat);
    checks++; if ({res1, fl1} !== {8'h80, 4'b1100}) begin failures++;
      $display("FAIL ovf_pos: got %h/%b expected %h/%b", res1, fl1, 8'h80, 4'b1100); end
    finish_txn();
    run_txn(8'h80, 8'h80, 2'b00, lat);
    checks++; if ({res1, fl1} !== {8'h00, 4'b0111}) begin failures++;
      $display("FAIL ovf_neg: got %h/%b expected %h/%b", res1, fl1, 8'h00, 4'b0111); end
    finish_txn();
  endtask

  task automatic test_backpressure();
    int lat;
    run_txn(8'h12, 8'h34, 2'b00, lat);
    checks++; if ({ov1, res1} !== {1'b1, 8'h46}) begin failures++;
      $display("FAIL bp_first: got %h expected %h", {ov1, res1}, {1'b1, 8'h46}); end
    // Competing upstream request must be ignored while the result is pending.
    iv1 = 1'b1; ia1 = 8'hFF; ib1 = 8'hFF; iop1 = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({ov1, ir1, res1, aa1, ab1, ac1} !== {1'b1, 1'b0, 8'h46, 8'h12, 8'h34, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: got %h expected %h", i,
                 {ov1, ir1, res1, aa1, ab1, ac1}, {1'b1, 1'b0, 8'h46, 8'h12, 8'h34, 1'b0});
      end
    end
    ordy1 = 1'b1;
    #1;
    checks++; if (ir1 !== 1'b0) begin failures++;
      $display("FAIL bp_no_bypass: got %b expected %b", ir1, 1'b0); end
    @(posedge clk); #1;
    checks++; if ({ov1, ir1, res1} !== {1'b0, 1'b1, 8'h46}) begin failures++;
      $display("FAIL bp_release: got %h expected %h", {ov1, ir1, res1}, {1'b0, 1'b1, 8'h46}); end
    iv1 = 1'b0; ordy1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_exec_reset();
    int lat;
    bit seen;
    iv2 = 1'b1; ia2 = 8'hFF; ib2 = 8'h01; iop2 = 2'b00;
    @(posedge clk); #1;
    iv2 = 1'b0;
    lat = 0;
    while (!ov2 && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 4) begin failures++;
      $display("FAIL s4_latency: got %0d expected %0d", lat, 4); end
    checks++; if ({res2, fl2} !== {8'h00, 4'b0011}) begin failures++;
      $display("FAIL s4_result: got %h/%b expected %h/%b", res2, fl2, 8'h00, 4'b0011); end
    ordy2 = 1'b1; @(posedge clk); #1; ordy2 = 1'b0;
    iv2 = 1'b1; ia2 = 8'h11; ib2 = 8'h22; iop2 = 2'b01;
    @(posedge clk); #1;
    iv2 = 1'b0;
    checks++; if ({ir2, ac2} !== 2'b01) begin failures++;
      $display("FAIL s4_adc_accept: got %b expected %b", {ir2, ac2}, 2'b01); end
    @(posedge clk); #1;
    rst_n2 = 1'b0;
    @(posedge clk); #1;
    rst_n2 = 1'b1;
    checks++;
    if ({ir2, ov2, aa2, ab2, ac2, res2, fl2} !== {2'b10, 8'h00, 8'h00, 1'b0, 8'h00, 4'h0}) begin
      failures++;
      $display("FAIL mid_reset_outputs: got %h expected %h", {ir2, ov2, aa2, ab2, ac2, res2, fl2},
               {2'b10, 8'h00, 8'h00, 1'b0, 8'h00, 4'h0});
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ov2) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++;
      $display("FAIL mid_reset_no_output: got %b expected %b", seen, 1'b0); end
    // Chain carry was cleared by reset, so ADC 0+0 must give 0.
    iv2 = 1'b1; ia2 = 8'h00; ib2 = 8'h00; iop2 = 2'b01;
    @(posedge clk); #1;
    iv2 = 1'b0;
    lat = 0;
    while (!ov2 && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++; if ({ac2, res2, fl2} !== {1'b0, 8'h00, 4'b0010}) begin failures++;
      $display("FAIL mid_reset_carry_cleared: got %h expected %h", {ac2, res2, fl2},
               {1'b0, 8'h00, 4'b0010}); end
    ordy2 = 1'b1; @(posedge clk); #1; ordy2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_adc_chain();
    test_sub();
    test_overflow();
    test_backpressure();
    test_mid_exec_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
